// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a shared column datapath.
// Optional MIXCOL_FWD_EN adds a fwd port that selects forward MixColumns per block.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef MIXCOL_FWD_EN
  ,
  input  logic         fwd
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] state_reg_q, state_reg_d;

  logic [3:0][7:0] a, x2, x4, x8;
  logic [3:0][7:0] inv_row;
  logic [31:0]     mix_col;

`ifdef MIXCOL_FWD_EN
  logic            mode_q, mode_d;
  logic [3:0][7:0] fwd_row;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // x9/xb/xd/xe are built from the doubled, quadrupled and octupled bytes.
  always_comb begin
    a       = state_reg_q[{col_cnt_q, 5'd0} +: 32];
    x2      = '0;
    x4      = '0;
    x8      = '0;
    inv_row = '0;
    for (int k = 0; k < 4; k++) begin
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
    end
    for (int r = 0; r < 4; r++) begin
      inv_row[2'(r)] = (x8[2'(r)]   ^ x4[2'(r)]   ^ x2[2'(r)])
                     ^ (x8[2'(r+1)] ^ x2[2'(r+1)] ^ a[2'(r+1)])
                     ^ (x8[2'(r+2)] ^ x4[2'(r+2)] ^ a[2'(r+2)])
                     ^ (x8[2'(r+3)] ^ a[2'(r+3)]);
    end
`ifdef MIXCOL_FWD_EN
    fwd_row = '0;
    for (int r = 0; r < 4; r++) begin
      fwd_row[2'(r)] = x2[2'(r)] ^ x2[2'(r+1)] ^ a[2'(r+1)] ^ a[2'(r+2)] ^ a[2'(r+3)];
    end
    mix_col = mode_q ? fwd_row : inv_row;
`else
    mix_col = inv_row;
`endif
  end

  always_comb begin
    fsm_d       = fsm_q;
    col_cnt_d   = col_cnt_q;
    state_reg_d = state_reg_q;
`ifdef MIXCOL_FWD_EN
    mode_d      = mode_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d       = RUN;
          state_reg_d = in_data;
          col_cnt_d   = 2'd0;
`ifdef MIXCOL_FWD_EN
          mode_d      = fwd;
`endif
        end
      end
      RUN: begin
        state_reg_d[{col_cnt_q, 5'd0} +: 32] = mix_col;
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d     = IDLE;
        col_cnt_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      col_cnt_q   <= 2'd0;
      state_reg_q <= '0;
`ifdef MIXCOL_FWD_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      col_cnt_q   <= col_cnt_d;
      state_reg_q <= state_reg_d;
`ifdef MIXCOL_FWD_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // All outputs come straight from registers; state_reg is zero after reset.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign out_data  = state_reg_q;

endmodule
